// File: rtl/dump_seq.sv
// Sample-buffer dump sequencer: reads 512 bytes from the sample RAM, oldest first, and
// hands each to a UART. Define DUMP_CHKSUM_EN to append a modulo-256 checksum byte.
module dump_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_dump,
  input  logic       capture_done,
  input  logic [8:0] start_addr,
  output logic [8:0] addr,
  output logic       en,
  input  logic [7:0] rdata,
  output logic [7:0] tx_data,
  output logic       send,
  input  logic       tx_done,
  output logic       busy,
  output logic       dump_finished,
  output logic       clr_capture_done
);

  typedef enum logic [3:0] {
    StIdle,
    StRead,
    StLatch,
    StSend,
    StWaitTx,
`ifdef DUMP_CHKSUM_EN
    StCkLoad,
    StCkSend,
    StCkWait,
`endif
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] ptr_q, ptr_d;
  logic [9:0] count_q, count_d;
  logic [7:0] tx_data_q, tx_data_d;
`ifdef DUMP_CHKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      count_q   <= '0;
      tx_data_q <= '0;
`ifdef DUMP_CHKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      tx_data_q <= tx_data_d;
`ifdef DUMP_CHKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    count_d          = count_q;
    tx_data_d        = tx_data_q;
`ifdef DUMP_CHKSUM_EN
    sum_d            = sum_q;
`endif
    en               = 1'b0;
    send             = 1'b0;
    dump_finished    = 1'b0;
    clr_capture_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A request without a complete capture is dropped, not queued.
        if (start_dump && capture_done) begin
          state_d = StRead;
          ptr_d   = start_addr;
          count_d = '0;
`ifdef DUMP_CHKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StRead: begin
        en      = 1'b1;
        state_d = StLatch;
      end
      StLatch: begin
        tx_data_d = rdata;
`ifdef DUMP_CHKSUM_EN
        sum_d     = sum_q + rdata;
`endif
        state_d   = StSend;
      end
      StSend: begin
        send    = 1'b1;
        state_d = StWaitTx;
      end
      StWaitTx: begin
        if (tx_done) begin
          if (count_q == 10'd511) begin
`ifdef DUMP_CHKSUM_EN
            state_d = StCkLoad;
`else
            state_d = StDone;
`endif
          end else begin
            ptr_d   = ptr_q + 9'd1;
            count_d = count_q + 10'd1;
            state_d = StRead;
          end
        end
      end
`ifdef DUMP_CHKSUM_EN
      StCkLoad: begin
        tx_data_d = sum_q;
        state_d   = StCkSend;
      end
      StCkSend: begin
        send    = 1'b1;
        state_d = StCkWait;
      end
      StCkWait: begin
        if (tx_done) state_d = StDone;
      end
`endif
      StDone: begin
        dump_finished    = 1'b1;
        clr_capture_done = 1'b1;
        state_d          = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign addr    = ptr_q;
  assign tx_data = tx_data_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: doc/dump_seq.md
DUMP_SEQ -- requirements
Module: dump_seq

Interface
REQ-001 SHALL have one clock and asynchronous active-high reset; clk, rst only.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start_dump  input  1  one-cycle request to dump the sample buffer.
REQ-005 capture_done  input  1  buffer holds a complete capture.
REQ-006 start_addr  input  9  oldest-sample address, sampled on accepted start_dump.
REQ-007 addr  output  9  sample RAM read address.
REQ-008 en  output  1  sample RAM enable (read only; write-enable never driven).
REQ-009 rdata  input  8  RAM read data, valid the cycle after en=1.
REQ-010 tx_data  output  8  byte presented to the UART transmitter.
REQ-011 send  output  1  one-cycle pulse: UART loads tx_data.
REQ-012 tx_done  input  1  one-cycle pulse: UART finished the current byte.
REQ-013 busy  output  1  high from accepted start until dump_finished inclusive.
REQ-014 dump_finished  output  1  one-cycle pulse after last byte's tx_done.
REQ-015 clr_capture_done  output  1  one-cycle pulse, coincident with dump_finished.

Function
REQ-016 States SHALL be IDLE, READ, LATCH, SEND, WAIT_TX, DONE.
REQ-017 IDLE: start_dump=1 and capture_done=1 -> READ; load ptr=start_addr, count=0; else stay.
REQ-018 start_dump with capture_done=0 SHALL be ignored; start_dump while busy SHALL be ignored.
REQ-019 READ: en=1, addr=ptr for exactly one cycle -> LATCH.
REQ-020 LATCH: tx_data<=rdata -> SEND.
REQ-021 SEND: send=1 for one cycle -> WAIT_TX; tx_data held stable until next LATCH.
REQ-022 WAIT_TX: on tx_done, if count=511 -> DONE, else ptr<=ptr+1, count<=count+1 -> READ.
REQ-023 ptr SHALL wrap 511->0 (9-bit modulo); exactly 512 samples sent, start_addr first.
REQ-024 count SHALL be 10 bits; no sample sent twice, none skipped.
REQ-025 DONE: dump_finished=1, clr_capture_done=1 for one cycle -> IDLE.
REQ-026 tx_done outside WAIT_TX SHALL be ignored.
REQ-027 Latency: start_dump accepted at edge N -> en=1 in cycle N+1, send=1 in cycle N+3.
REQ-028 en, send, dump_finished, clr_capture_done SHALL be 0 in every state not listed.

Reset
REQ-029 rst=1 SHALL immediately force IDLE; addr=0, en=0, tx_data=0, send=0, busy=0, dump_finished=0, clr_capture_done=0, ptr=0, count=0.
REQ-030 rst mid-dump SHALL abort without dump_finished or clr_capture_done; next dump restarts from start_addr.

Configuration
REQ-031 Macro DUMP_CHKSUM_EN: when defined, after the 512th tx_done the block SHALL send one extra byte = 8-bit modulo-256 sum of all 512 samples (send, wait tx_done), then DONE.
REQ-032 Without DUMP_CHKSUM_EN: exactly 512 bytes, no checksum logic present.
REQ-033 Checksum accumulator SHALL clear on accepted start_dump and on rst.

Verification
REQ-034 RAM[i]=i[7:0], capture_done=1, start_addr=0, start_dump pulse, UART tx_done 10 cycles after send -> bytes 0x00..0xFF,0x00..0xFF, one dump_finished+clr_capture_done pulse.
REQ-035 start_addr=500 -> first addr 500, addr 511 followed by 0, last addr 499, 512 sends.
REQ-036 capture_done=0, start_dump pulse -> en, send, busy stay 0 for 20 cycles.
REQ-037 Second start_dump at byte 3 of dump -> ignored, sequence unchanged, single dump_finished.
REQ-038 rst=1 during WAIT_TX of byte 100 -> all outputs 0 same cycle, no dump_finished; new start -> restarts at start_addr.
REQ-039 DUMP_CHKSUM_EN, RAM all 0x01 -> 513 sends, final byte 0x00 (512 mod 256), then dump_finished.
